// File: rtl/cdb_writeback_pkg.sv
// Shared widths and bus payloads for the writeback / CDB broadcast stage.
package cdb_writeback_pkg;

   localparam int unsigned CDB_NUM_FU      = 4;
   localparam int unsigned CDB_XLEN        = 32;
   localparam int unsigned CDB_PHYS_REG_SZ = 64;
   localparam int unsigned CDB_PREG_W      = $clog2(CDB_PHYS_REG_SZ);
   localparam int unsigned CDB_FU_IDX_W    = $clog2(CDB_NUM_FU);

   typedef struct packed {
      logic                    en;
      logic [CDB_PREG_W-1:0]   tag;
      logic [CDB_XLEN-1:0]     data;
   } ic_prf_packet_t;

   typedef struct packed {
      logic                    valid;
      logic [CDB_PREG_W-1:0]   tag;
      logic [CDB_FU_IDX_W-1:0] fu;
   } cdb_packet_t;

endpackage

// File: rtl/cdb_writeback_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, wrapping modulo N.
module cdb_writeback_rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any_gnt
);

   int unsigned idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr) + k) % N;
         if (!any_gnt && req[IW'(idx)]) begin
            any_gnt          = 1'b1;
            gnt_idx          = IW'(idx);
            gnt[IW'(idx)]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_writeback.sv
// Complete stage: buffers one result per FU and broadcasts one per cycle on the
// PRF write port and CDB, chosen round-robin.
module cdb_writeback
   import cdb_writeback_pkg::*;
#(
   parameter  int unsigned NUM_FU   = CDB_NUM_FU,
   parameter  int unsigned XLEN     = CDB_XLEN,
   parameter  int unsigned PREG_W   = CDB_PREG_W,
   localparam int unsigned FU_IDX_W = $clog2(NUM_FU)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           squash,
   input  logic [NUM_FU-1:0]              fu_valid,
   input  logic [NUM_FU-1:0][PREG_W-1:0]  fu_tag,
   input  logic [NUM_FU-1:0][XLEN-1:0]    fu_data,
   output logic [NUM_FU-1:0]              fu_ready,
   output logic                           prf_write_en,
   output logic [PREG_W-1:0]              prf_write_tag,
   output logic [XLEN-1:0]                prf_write_data,
   output logic                           cdb_valid,
   output logic [PREG_W-1:0]              cdb_tag,
   output logic [FU_IDX_W-1:0]            cdb_fu
);

   logic [NUM_FU-1:0]             hold_valid;
   logic [NUM_FU-1:0][PREG_W-1:0] hold_tag;
   logic [NUM_FU-1:0][XLEN-1:0]   hold_data;
   logic [FU_IDX_W-1:0]           rr_ptr;

   logic [NUM_FU-1:0]   req;
   logic [NUM_FU-1:0]   gnt;
   logic [NUM_FU-1:0]   accept;
   logic [FU_IDX_W-1:0] gnt_idx;
   logic [FU_IDX_W-1:0] next_ptr;
   logic                any_gnt;
   logic                flush;

   ic_prf_packet_t prf_pkt;
   cdb_packet_t    cdb_pkt;

   // Reset and squash both suppress the grant, so nothing escapes to the PRF.
   assign flush = squash | reset;
   assign req   = flush ? '0 : hold_valid;

   cdb_writeback_rr_arbiter #(.N(NUM_FU)) u_arb (
      .req     (req),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   // A slot granted this cycle may be refilled at the same edge.
   assign fu_ready = flush ? '0 : (~hold_valid | gnt);
   assign accept   = fu_valid & fu_ready;
   assign next_ptr = (gnt_idx == FU_IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + FU_IDX_W'(1);

   // Broadcast payloads; tag 0 still broadcasts but never writes the PRF.
   always_comb begin
      prf_pkt = '0;
      cdb_pkt = '0;
      if (any_gnt) begin
         prf_pkt.en    = (hold_tag[gnt_idx] != '0);
         prf_pkt.tag   = hold_tag[gnt_idx];
         prf_pkt.data  = hold_data[gnt_idx];
         cdb_pkt.valid = 1'b1;
         cdb_pkt.tag   = hold_tag[gnt_idx];
         cdb_pkt.fu    = gnt_idx;
      end
   end

   assign prf_write_en   = prf_pkt.en;
   assign prf_write_tag  = prf_pkt.tag;
   assign prf_write_data = prf_pkt.data;
   assign cdb_valid      = cdb_pkt.valid;
   assign cdb_tag        = cdb_pkt.tag;
   assign cdb_fu         = cdb_pkt.fu;

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid <= '0;
         rr_ptr     <= '0;
      end else if (squash) begin
         hold_valid <= '0;
      end else begin
         hold_valid <= accept | (hold_valid & ~gnt);
         if (any_gnt) begin
            rr_ptr <= next_ptr;
         end
      end
   end

   // Payload storage needs no reset; hold_valid qualifies it.
   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (accept[i]) begin
            hold_tag[i]  <= fu_tag[i];
            hold_data[i] <= fu_data[i];
         end
      end
   end

endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: directed sequences plus a per-FU result scoreboard.
module tb_cdb_writeback;
   import cdb_writeback_pkg::*;

   localparam int unsigned NF = CDB_NUM_FU;
   localparam int unsigned XW = CDB_XLEN;
   localparam int unsigned PW = CDB_PREG_W;
   localparam int unsigned IW = $clog2(NF);

   logic                  clock;
   logic                  reset;
   logic                  squash;
   logic [NF-1:0]         fu_valid;
   logic [NF-1:0][PW-1:0] fu_tag;
   logic [NF-1:0][XW-1:0] fu_data;
   logic [NF-1:0]         fu_ready;
   logic                  prf_write_en;
   logic [PW-1:0]         prf_write_tag;
   logic [XW-1:0]         prf_write_data;
   logic                  cdb_valid;
   logic [PW-1:0]         cdb_tag;
   logic [IW-1:0]         cdb_fu;

   cdb_writeback dut (
      .clock          (clock),
      .reset          (reset),
      .squash         (squash),
      .fu_valid       (fu_valid),
      .fu_tag         (fu_tag),
      .fu_data        (fu_data),
      .fu_ready       (fu_ready),
      .prf_write_en   (prf_write_en),
      .prf_write_tag  (prf_write_tag),
      .prf_write_data (prf_write_data),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_fu         (cdb_fu)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int unsigned   fu;
      logic [PW-1:0] tag;
      logic [XW-1:0] data;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic chk_out(input string tag, input logic v, input int unsigned fu,
                          input int unsigned t, input logic en, input int unsigned d);
      chk({tag, "_cdb_valid"}, 64'(cdb_valid),      64'(v));
      chk({tag, "_cdb_fu"},    64'(cdb_fu),         64'(fu));
      chk({tag, "_cdb_tag"},   64'(cdb_tag),        64'(t));
      chk({tag, "_prf_tag"},   64'(prf_write_tag),  64'(t));
      chk({tag, "_prf_en"},    64'(prf_write_en),   64'(en));
      chk({tag, "_prf_data"},  64'(prf_write_data), 64'(d));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_fu(input int unsigned i, input int unsigned t, input int unsigned d);
      fu_valid[i] = 1'b1;
      fu_tag[i]   = PW'(t);
      fu_data[i]  = XW'(d);
   endtask

   // Scoreboard: pop the oldest result of the granted FU, then log new handshakes.
   int        sb_idx;
   sb_entry_t sb_e;
   always @(negedge clock) begin
      if (cdb_valid) begin
         sb_idx = -1;
         for (int k = 0; k < sb_q.size(); k++)
            if (sb_idx < 0 && sb_q[k].fu == 32'(cdb_fu)) sb_idx = k;
         if (sb_idx < 0) begin
            chk("sb_unexpected_grant", 64'(cdb_fu), 64'hFF);
         end else begin
            sb_e = sb_q[sb_idx];
            sb_q.delete(sb_idx);
            chk("sb_cdb_tag",  64'(cdb_tag),        64'(sb_e.tag));
            chk("sb_prf_tag",  64'(prf_write_tag),  64'(sb_e.tag));
            chk("sb_prf_data", 64'(prf_write_data), 64'(sb_e.data));
            chk("sb_prf_en",   64'(prf_write_en),   64'(sb_e.tag != '0));
         end
      end else begin
         chk("idle_prf_en", 64'(prf_write_en), 64'(0));
      end
      if (reset || squash) begin
         sb_q.delete();
      end else begin
         for (int i = 0; i < int'(NF); i++)
            if (fu_valid[i] && fu_ready[i])
               sb_q.push_back('{fu: i, tag: fu_tag[i], data: fu_data[i]});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   logic [NF-1:0] r;
   int unsigned   seq;

   initial begin
      reset    = 1'b1;
      squash   = 1'b0;
      fu_valid = '0;
      fu_tag   = '0;
      fu_data  = '0;

      // Reset state
      @(negedge clock);
      chk("reset_ready", 64'(fu_ready), 64'(0));
      chk_out("reset", 1'b0, 0, 0, 1'b0, 0);
      step(); reset = 1'b0;
      @(negedge clock);
      chk_out("post_reset", 1'b0, 0, 0, 1'b0, 0);
      chk("post_reset_ready", 64'(fu_ready), 64'(4'b1111));

      // Single result, one-cycle latency
      step(); drive_fu(1, 5, 32'hDEAD);
      @(negedge clock);
      chk_out("single_pre", 1'b0, 0, 0, 1'b0, 0);
      step(); fu_valid = '0;
      @(negedge clock);
      chk_out("single", 1'b1, 1, 5, 1'b1, 32'hDEAD);
      step();
      @(negedge clock);
      chk_out("single_after", 1'b0, 0, 0, 1'b0, 0);

      // Contention from rr_ptr=0
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      for (int unsigned i = 0; i < 4; i++) drive_fu(i, 10 + i, 100 + i);
      @(negedge clock);
      chk("cont_ready_all", 64'(fu_ready), 64'(4'b1111));
      step(); fu_valid = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         @(negedge clock);
         chk_out("cont", 1'b1, k, 10 + k, 1'b1, 100 + k);
         chk("cont_ready", 64'(fu_ready), 64'((1 << (k + 1)) - 1));
         step();
      end

      // Fairness: FU0 and FU2 refill every accepted cycle
      seq = 20;
      drive_fu(0, seq, 1000 + seq); seq++;
      drive_fu(2, seq, 1000 + seq); seq++;
      for (int unsigned n = 0; n <= 6; n++) begin
         @(negedge clock);
         r = fu_ready;
         if (n == 0) begin
            chk("fair_ready0", 64'(r), 64'(4'b1111));
         end else begin
            chk("fair_fu", 64'(cdb_fu), 64'((n % 2 == 1) ? 0 : 2));
            chk("fair_ready", 64'(r), 64'((n % 2 == 1) ? 4'b1011 : 4'b1110));
         end
         step();
         if (n == 6) begin
            fu_valid = '0;
         end else begin
            if (r[0]) begin drive_fu(0, seq, 1000 + seq); seq++; end
            if (r[2]) begin drive_fu(2, seq, 1000 + seq); seq++; end
         end
      end
      repeat (3) begin
         @(negedge clock);
         step();
      end

      // Tag 0 broadcasts without a PRF write
      drive_fu(3, 0, 7);
      @(negedge clock);
      step(); fu_valid = '0;
      @(negedge clock);
      chk_out("tag0", 1'b1, 3, 0, 1'b0, 7);
      step();
      @(negedge clock);
      chk("tag0_freed", 64'(fu_ready), 64'(4'b1111));
      chk("tag0_idle", 64'(cdb_valid), 64'(0));

      // Squash with slots 1 and 2 held
      step(); drive_fu(1, 30, 300); drive_fu(2, 31, 310);
      @(negedge clock);
      step(); fu_valid = '0; squash = 1'b1;
      @(negedge clock);
      chk_out("squash", 1'b0, 0, 0, 1'b0, 0);
      chk("squash_ready", 64'(fu_ready), 64'(0));
      step(); squash = 1'b0;
      @(negedge clock);
      chk_out("post_squash", 1'b0, 0, 0, 1'b0, 0);
      chk("post_squash_ready", 64'(fu_ready), 64'(4'b1111));

      // Move rr_ptr to 3, then reset with three slots held
      step(); drive_fu(2, 9, 9);
      @(negedge clock);
      step(); fu_valid = '0;
      @(negedge clock);
      chk("ptr_move_fu", 64'(cdb_fu), 64'(2));
      step(); drive_fu(0, 40, 400); drive_fu(1, 41, 410); drive_fu(3, 43, 430);
      @(negedge clock);
      step(); fu_valid = '0; reset = 1'b1;
      @(negedge clock);
      chk_out("mid_reset", 1'b0, 0, 0, 1'b0, 0);
      chk("mid_reset_ready", 64'(fu_ready), 64'(0));
      step(); reset = 1'b0;
      @(negedge clock);
      chk_out("after_reset", 1'b0, 0, 0, 1'b0, 0);
      chk("after_reset_ready", 64'(fu_ready), 64'(4'b1111));

      // rr_ptr back at 0: FU1 wins over FU3
      step(); drive_fu(3, 50, 500); drive_fu(1, 51, 510);
      @(negedge clock);
      step(); fu_valid = '0;
      @(negedge clock);
      chk_out("ptr0_first", 1'b1, 1, 51, 1'b1, 510);
      step();
      @(negedge clock);
      chk_out("ptr0_second", 1'b1, 3, 50, 1'b1, 500);
      step();
      @(negedge clock);
      chk_out("final_idle", 1'b0, 0, 0, 1'b0, 0);
      chk("sb_drained", 64'(sb_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
